// File: rtl/l2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter_if
// Brief    : L1-side request/response and L2-side command bundle for the arbiter
// Revision : 1.0
// ============================================================================
interface l2_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    // Arbiter side
    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );

    // Environment side: L1 controllers plus L2 cache
    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Brief    : Round-robin arbiter sharing one L2 port between I-L1 and D-L1
// Revision : 1.0
// ============================================================================
module l2_arbiter (
    input  wire          clk,
    input  wire          rst,
    l2_arbiter_if.slave  bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT_I = 2'd1;
    localparam logic [1:0] c_GRANT_D = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_grant;      // 0 = I, 1 = D
    logic       w_last_grant_nxt;
    logic       w_i_req;
    logic       w_d_req;

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_IDLE: begin
                // On a tie the side that did not win last time goes next
                if (w_i_req && (!w_d_req || r_last_grant)) begin
                    w_state_nxt      = c_GRANT_I;
                    w_last_grant_nxt = 1'b0;
                end else if (w_d_req) begin
                    w_state_nxt      = c_GRANT_D;
                    w_last_grant_nxt = 1'b1;
                end
            end
            c_GRANT_I: if (bus.l2_resp) w_state_nxt = c_IDLE;
            c_GRANT_D: if (bus.l2_resp) w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        bus.l2_read    = 1'b0;
        bus.l2_write   = 1'b0;
        bus.l2_address = bus.i_address;
        bus.l2_wdata   = bus.d_wdata;
        bus.i_resp     = 1'b0;
        bus.d_resp     = 1'b0;
        bus.i_rdata    = bus.l2_rdata;
        bus.d_rdata    = bus.l2_rdata;
        case (r_state)
            c_GRANT_I: begin
                bus.l2_read = bus.i_read;
                bus.i_resp  = bus.l2_resp;
            end
            c_GRANT_D: begin
                bus.l2_read    = bus.d_read;
                bus.l2_write   = bus.d_write;
                bus.l2_address = bus.d_address;
                bus.d_resp     = bus.l2_resp;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_arbiter
// Brief    : Directed self-checking bench for l2_arbiter
// Revision : 1.0
// ============================================================================
module tb_l2_arbiter;
    localparam int c_ADDR_W = 32;
    localparam int c_LINE_W = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [c_LINE_W-1:0] c_A5   = {32{8'hA5}};
    logic [c_LINE_W-1:0] c_WD   = {8{32'h1234_5678}};
    logic [c_LINE_W-1:0] c_RD   = {4{64'hDEAD_BEEF_0BAD_F00D}};
    logic [c_ADDR_W-1:0] c_IADR = 32'h0000_1000;
    logic [c_ADDR_W-1:0] c_DADR = 32'h8000_0040;

    l2_arbiter_if #(.ADDR_W(c_ADDR_W), .LINE_W(c_LINE_W)) bus ();

    l2_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_LINE_W-1:0] obs,
                       input logic [c_LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs are applied afterwards and stay stable
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_quiet(input string tag);
        chk({tag, "_l2_read"},  bus.l2_read,  1'b0);
        chk({tag, "_l2_write"}, bus.l2_write, 1'b0);
        chk({tag, "_i_resp"},   bus.i_resp,   1'b0);
        chk({tag, "_d_resp"},   bus.d_resp,   1'b0);
    endtask

    initial begin
        bus.i_read    = 1'b0;
        bus.i_address = 32'h0000_0055;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = 32'h0000_0077;
        bus.d_wdata   = c_WD;
        bus.l2_rdata  = '0;
        bus.l2_resp   = 1'b0;

        // Reset state: commands/responses low, IDLE address/data forwarding
        rst = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        idle_quiet("rst");
        chk("rst_addr",  bus.l2_address, 32'h0000_0055);
        chk("rst_wdata", bus.l2_wdata,   c_WD);
        rst = 1'b1;

        // Single I fill: l2_read cycles 1-4, resp in cycle 4
        next_cycle();
        bus.i_read = 1'b1; bus.i_address = c_IADR; settle();
        chk("if_c0_l2_read", bus.l2_read, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            bus.l2_resp  = (c == 4);
            bus.l2_rdata = (c == 4) ? c_A5 : '0;
            settle();
            chk("if_l2_read", bus.l2_read, 1'b1);
            chk("if_l2_write", bus.l2_write, 1'b0);
            chk("if_addr", bus.l2_address, c_IADR);
            chk("if_i_resp", bus.i_resp, (c == 4));
            chk("if_d_resp", bus.d_resp, 1'b0);
        end
        chk("if_i_rdata", bus.i_rdata, c_A5);
        next_cycle();
        bus.i_read = 1'b0; bus.l2_resp = 1'b0; settle();
        idle_quiet("if_c5");

        // D writeback
        next_cycle();
        bus.d_write = 1'b1; bus.d_address = c_DADR; settle();
        chk("wb_c0_l2_write", bus.l2_write, 1'b0);
        chk("wb_c0_addr", bus.l2_address, c_IADR);
        next_cycle(); settle();
        chk("wb_l2_write", bus.l2_write, 1'b1);
        chk("wb_l2_read", bus.l2_read, 1'b0);
        chk("wb_addr", bus.l2_address, c_DADR);
        chk("wb_wdata", bus.l2_wdata, c_WD);
        chk("wb_d_resp_early", bus.d_resp, 1'b0);
        next_cycle();
        bus.l2_resp = 1'b1; settle();
        chk("wb_d_resp", bus.d_resp, 1'b1);
        chk("wb_i_resp", bus.i_resp, 1'b0);
        next_cycle();
        bus.d_write = 1'b0; bus.l2_resp = 1'b0; settle();
        idle_quiet("wb_idle");

        // Only D requesting with last_grant = D: still granted each time
        next_cycle();
        bus.d_read = 1'b1; settle();
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            bus.l2_resp  = (c % 2 == 1);
            bus.l2_rdata = c_RD;
            settle();
            chk("od_l2_read", bus.l2_read, (c % 2 == 1));
            chk("od_d_resp", bus.d_resp, (c % 2 == 1));
            chk("od_i_resp", bus.i_resp, 1'b0);
        end
        chk("od_d_rdata", bus.d_rdata, c_RD);
        bus.d_read = 1'b0; bus.l2_resp = 1'b0;

        // Reset, then both requesting: grants alternate I, D, I, D
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        bus.i_read = 1'b1; bus.d_read = 1'b1; settle();
        chk("tie_c0_l2_read", bus.l2_read, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            bus.l2_resp = (k % 2 == 1);
            settle();
            chk("tie_l2_read", bus.l2_read, (k % 2 == 1));
            chk("tie_i_resp", bus.i_resp, (k % 4 == 1));
            chk("tie_d_resp", bus.d_resp, (k % 4 == 3));
            if (k % 2 == 1)
                chk("tie_addr", bus.l2_address, (k % 4 == 1) ? c_IADR : c_DADR);
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.l2_resp = 1'b0;

        // Reset in the 2nd cycle of GRANT_D, late l2_resp ignored
        next_cycle();
        bus.d_write = 1'b1; settle();
        next_cycle(); settle();
        chk("mr_c1_l2_write", bus.l2_write, 1'b1);
        next_cycle();
        rst = 1'b0; settle();
        chk("mr_c2_l2_write", bus.l2_write, 1'b1);
        next_cycle();
        rst = 1'b1; bus.d_write = 1'b0; settle();
        idle_quiet("mr_c3");
        next_cycle();
        bus.l2_resp = 1'b1; settle();
        idle_quiet("mr_c4");
        next_cycle();
        bus.l2_resp = 1'b0; bus.i_read = 1'b1; bus.d_read = 1'b1; settle();
        idle_quiet("mr_c5");
        next_cycle();
        bus.l2_resp = 1'b1; settle();
        chk("mr_tie_addr", bus.l2_address, c_IADR);
        chk("mr_tie_i_resp", bus.i_resp, 1'b1);
        chk("mr_tie_d_resp", bus.d_resp, 1'b0);
        next_cycle();
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.l2_resp = 1'b0; settle();

        // Spurious l2_resp in IDLE with no requests
        next_cycle();
        bus.l2_resp = 1'b1; settle();
        idle_quiet("sp_c0");
        next_cycle();
        bus.l2_resp = 1'b0; bus.d_read = 1'b1; settle();
        chk("sp_c1_l2_read", bus.l2_read, 1'b0);
        next_cycle(); settle();
        chk("sp_c2_l2_read", bus.l2_read, 1'b1);
        chk("sp_c2_addr", bus.l2_address, c_DADR);
        bus.d_read = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
